// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcode constants, FSM state type and size defaults for
//            the ALU issue/writeback controller.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int ALU_W     = 16;
    localparam int ALU_NREGS = 8;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_if
// Purpose  : Register-addressed request handshake into the issue controller.
// Revision : 1.0
// ============================================================================
interface alu_issue_if #(
    parameter int AW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_rd;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Purpose  : NREGS x W register file, three combinational reads, sync reset.
// Revision : 1.0
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int NREGS = ALU_NREGS,
    parameter  int W     = ALU_W,
    localparam int AW    = $clog2(NREGS)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic [AW-1:0] rs1_addr,
    output logic      [W-1:0]  rs1_data,
    input  wire logic [AW-1:0] rs2_addr,
    output logic      [W-1:0]  rs2_data,
    input  wire logic [AW-1:0] dbg_addr,
    output logic      [W-1:0]  dbg_data,
    input  wire logic          host_we,
    input  wire logic [AW-1:0] host_addr,
    input  wire logic [W-1:0]  host_data,
    input  wire logic          wb_we,
    input  wire logic [AW-1:0] wb_addr,
    input  wire logic [W-1:0]  wb_data
);

    logic [W-1:0] r_mem [NREGS];

    assign rs1_data = r_mem[rs1_addr];
    assign rs2_data = r_mem[rs2_addr];
    assign dbg_data = r_mem[dbg_addr];

    // Host and writeback can both land on one edge; the caller masks host_we
    // on an address collision so the two never target the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (host_we) begin
                r_mem[host_addr] <= host_data;
            end
            if (wb_we) begin
                r_mem[wb_addr] <= wb_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Purpose  : Issue/writeback controller feeding a 16-bit combinational ALU.
//            Optional {N,Z,C} flags enabled by macro ALU_ISSUE_FLAGS_EN.
// Revision : 1.0
// ============================================================================
module alu_issue
    import alu_pkg::*;
#(
    parameter  int NREGS = ALU_NREGS,
    parameter  int W     = ALU_W,
    localparam int AW    = $clog2(NREGS)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alu_issue_if.slave         req,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [W-1:0]  wr_data,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [W-1:0]  rd_data,
    output logic      [1:0]    alu_op,
    output logic      [W-1:0]  alu_i0,
    output logic      [W-1:0]  alu_i1,
    input  wire logic [W-1:0]  alu_o,
    input  wire logic          alu_cout,
    output logic               done,
    output logic      [AW-1:0] done_rd,
    output logic      [W-1:0]  result
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic      [2:0]    flags
`endif
);

    state_t        r_state;
    logic          r_ready;
    logic          r_done;
    logic [AW-1:0] r_rd;
    logic [1:0]    r_op;
    logic [W-1:0]  r_i0;
    logic [W-1:0]  r_i1;
    logic [W-1:0]  r_result;

    logic [W-1:0]  w_rs1_data;
    logic [W-1:0]  w_rs2_data;
    logic          w_wb_we;
    logic          w_host_we;

    // Writeback beats a host load to the same register on the same edge.
    assign w_wb_we   = (r_state == WB);
    assign w_host_we = wr_en && !(w_wb_we && (wr_addr == r_rd));

    alu_regfile #(
        .NREGS (NREGS),
        .W     (W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rs1_addr  (req.req_rs1),
        .rs1_data  (w_rs1_data),
        .rs2_addr  (req.req_rs2),
        .rs2_data  (w_rs2_data),
        .dbg_addr  (rd_addr),
        .dbg_data  (rd_data),
        .host_we   (w_host_we),
        .host_addr (wr_addr),
        .host_data (wr_data),
        .wb_we     (w_wb_we),
        .wb_addr   (r_rd),
        .wb_data   (r_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_rd     <= '0;
            r_op     <= '0;
            r_i0     <= '0;
            r_i1     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req.req_valid) begin
                        r_op    <= req.req_op;
                        r_i0    <= w_rs1_data;
                        r_i1    <= w_rs2_data;
                        r_rd    <= req.req_rd;
                        r_ready <= 1'b0;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= alu_o;
                    r_done   <= 1'b1;
                    r_state  <= WB;
                end
                WB: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req.req_ready = r_ready;
    assign done          = r_done;
    assign done_rd       = r_rd;
    assign alu_op        = r_op;
    assign alu_i0        = r_i0;
    assign alu_i1        = r_i1;
    assign result        = r_result;

`ifdef ALU_ISSUE_FLAGS_EN
    logic [2:0] r_flags;
    logic       r_cout;

    // Logic ops leave C untouched; only add/sub refresh it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
            r_cout  <= 1'b0;
        end else begin
            if (r_state == EXEC) begin
                r_cout <= alu_cout;
            end
            if (r_state == WB) begin
                r_flags[2] <= r_result[W-1];
                r_flags[1] <= (r_result == '0);
                if ((r_op == ALU_ADD) || (r_op == ALU_SUB)) begin
                    r_flags[0] <= r_cout;
                end
            end
        end
    end

    assign flags = r_flags;
`else
    logic w_unused_cout;
    assign w_unused_cout = alu_cout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Purpose  : Directed self-checking bench for alu_issue with a behavioural ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_issue;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [1:0]  alu_op;
    logic [15:0] alu_i0;
    logic [15:0] alu_i1;
    logic [15:0] alu_o;
    logic        alu_cout;
    logic        done;
    logic [2:0]  done_rd;
    logic [15:0] result;
`ifdef ALU_ISSUE_FLAGS_EN
    logic [2:0]  flags;
`endif

    int checks = 0;
    int passed = 0;

    alu_issue_if #(.AW(3)) req_bus ();

    alu_issue #(.NREGS(8), .W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req_bus),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .alu_op   (alu_op),
        .alu_i0   (alu_i0),
        .alu_i1   (alu_i1),
        .alu_o    (alu_o),
        .alu_cout (alu_cout),
        .done     (done),
        .done_rd  (done_rd),
        .result   (result)
`ifdef ALU_ISSUE_FLAGS_EN
        ,
        .flags    (flags)
`endif
    );

    // Behavioural ALU: sub is i0 + ~i1 + 1, so cout=1 means no borrow.
    always_comb begin
        alu_o    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00:   {alu_cout, alu_o} = {1'b0, alu_i0} + {1'b0, alu_i1};
            2'b01:   {alu_cout, alu_o} = {1'b0, alu_i0} + {1'b0, ~alu_i1} + 17'd1;
            2'b10:   alu_o = alu_i0 & alu_i1;
            default: alu_o = alu_i0 | alu_i1;
        endcase
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [2:0] a, output logic [15:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2);
        req_bus.req_valid = 1'b1;
        req_bus.req_op    = op;
        req_bus.req_rd    = rd;
        req_bus.req_rs1   = rs1;
        req_bus.req_rs2   = rs2;
        tick();
        req_bus.req_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (req_bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_bus.req_ready); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        checks++; if (done_rd !== 3'd0) $display("FAIL reset_done_rd: got %0d expected 0", done_rd); else passed++;
        checks++; if (result !== 16'h0000) $display("FAIL reset_result: got %h expected 0000", result); else passed++;
        checks++; if (alu_op !== 2'b00) $display("FAIL reset_alu_op: got %b expected 00", alu_op); else passed++;
        checks++; if ({alu_i0, alu_i1} !== 32'h0) $display("FAIL reset_operands: got %h/%h expected 0000/0000", alu_i0, alu_i1); else passed++;
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (flags !== 3'b000) $display("FAIL reset_flags: got %b expected 000", flags); else passed++;
`endif
        peek(3'd0, v);
        checks++; if (v !== 16'h0000) $display("FAIL reset_r0: got %h expected 0000", v); else passed++;
        peek(3'd7, v);
        checks++; if (v !== 16'h0000) $display("FAIL reset_r7: got %h expected 0000", v); else passed++;
    endtask

    task automatic test_add();
        logic [15:0] v;
        load(3'd1, 16'haa55);
        load(3'd2, 16'h55aa);
        req_bus.req_valid = 1'b1;
        req_bus.req_op    = 2'b00;
        req_bus.req_rd    = 3'd3;
        req_bus.req_rs1   = 3'd1;
        req_bus.req_rs2   = 3'd2;
        tick();
        req_bus.req_valid = 1'b0;
        checks++; if (req_bus.req_ready !== 1'b0) $display("FAIL add_exec_ready: got %b expected 0", req_bus.req_ready); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL add_exec_done: got %b expected 0", done); else passed++;
        checks++; if ({alu_i0, alu_i1} !== 32'haa55_55aa) $display("FAIL add_operands: got %h/%h expected aa55/55aa", alu_i0, alu_i1); else passed++;
        tick();
        checks++; if (done !== 1'b1) $display("FAIL add_wb_done: got %b expected 1", done); else passed++;
        checks++; if (done_rd !== 3'd3) $display("FAIL add_done_rd: got %0d expected 3", done_rd); else passed++;
        checks++; if (result !== 16'hffff) $display("FAIL add_result: got %h expected ffff", result); else passed++;
        tick();
        checks++; if (done !== 1'b0) $display("FAIL add_done_clear: got %b expected 0", done); else passed++;
        checks++; if (req_bus.req_ready !== 1'b1) $display("FAIL add_ready_back: got %b expected 1", req_bus.req_ready); else passed++;
        peek(3'd3, v);
        checks++; if (v !== 16'hffff) $display("FAIL add_r3: got %h expected ffff", v); else passed++;
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (flags !== 3'b100) $display("FAIL add_flags: got %b expected 100", flags); else passed++;
`endif
    endtask

    task automatic test_carry_sub();
        logic [15:0] v;
        load(3'd1, 16'hffff);
        load(3'd2, 16'h0001);
        run_op(2'b00, 3'd4, 3'd1, 3'd2);
        peek(3'd4, v);
        checks++; if (v !== 16'h0000) $display("FAIL carry_r4: got %h expected 0000", v); else passed++;
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (flags !== 3'b011) $display("FAIL carry_flags: got %b expected 011", flags); else passed++;
`endif
        load(3'd1, 16'h0001);
        load(3'd2, 16'h7fff);
        run_op(2'b01, 3'd5, 3'd1, 3'd2);
        peek(3'd5, v);
        checks++; if (v !== 16'h8002) $display("FAIL sub_r5: got %h expected 8002", v); else passed++;
        checks++; if (result !== 16'h8002) $display("FAIL sub_result: got %h expected 8002", result); else passed++;
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (flags !== 3'b100) $display("FAIL sub_flags: got %b expected 100", flags); else passed++;
`endif
    endtask

    task automatic test_logic();
        logic [15:0] v;
        load(3'd1, 16'hffff);
        load(3'd2, 16'h0001);
        run_op(2'b00, 3'd6, 3'd1, 3'd2);
        load(3'd1, 16'haa55);
        load(3'd2, 16'h55aa);
        run_op(2'b10, 3'd6, 3'd1, 3'd2);
        peek(3'd6, v);
        checks++; if (v !== 16'h0000) $display("FAIL and_r6: got %h expected 0000", v); else passed++;
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (flags !== 3'b011) $display("FAIL and_flags: got %b expected 011", flags); else passed++;
`endif
        run_op(2'b11, 3'd7, 3'd1, 3'd2);
        peek(3'd7, v);
        checks++; if (v !== 16'hffff) $display("FAIL or_r7: got %h expected ffff", v); else passed++;
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (flags !== 3'b101) $display("FAIL or_flags: got %b expected 101", flags); else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0004);
        req_bus.req_valid = 1'b1;
        req_bus.req_op    = 2'b00;
        req_bus.req_rd    = 3'd5;
        req_bus.req_rs1   = 3'd1;
        req_bus.req_rs2   = 3'd2;
        tick();
        checks++; if (req_bus.req_ready !== 1'b0) $display("FAIL b2b_ready_exec: got %b expected 0", req_bus.req_ready); else passed++;
        tick();
        checks++; if ({req_bus.req_ready, done} !== 2'b01) $display("FAIL b2b_wb_state: got ready/done %b expected 01", {req_bus.req_ready, done}); else passed++;
        tick();
        checks++; if ({req_bus.req_ready, done} !== 2'b10) $display("FAIL b2b_idle_state: got ready/done %b expected 10", {req_bus.req_ready, done}); else passed++;
        checks++; if (alu_op !== 2'b00) $display("FAIL b2b_no_early_accept: got op %b expected 00", alu_op); else passed++;
        peek(3'd5, v);
        checks++; if (v !== 16'h0007) $display("FAIL b2b_r5: got %h expected 0007", v); else passed++;
        req_bus.req_op = 2'b01;
        req_bus.req_rd = 3'd6;
        tick();
        req_bus.req_valid = 1'b0;
        checks++; if ({req_bus.req_ready, alu_op} !== 3'b001) $display("FAIL b2b_second_accept: got ready/op %b expected 001", {req_bus.req_ready, alu_op}); else passed++;
        tick();
        checks++; if ({done, done_rd} !== 4'b1110) $display("FAIL b2b_done_rd: got done/rd %b expected 1110", {done, done_rd}); else passed++;
        checks++; if (result !== 16'hffff) $display("FAIL b2b_result: got %h expected ffff", result); else passed++;
        wr_en   = 1'b1;
        wr_addr = 3'd6;
        wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        peek(3'd6, v);
        checks++; if (v !== 16'hffff) $display("FAIL wb_beats_host: got %h expected ffff", v); else passed++;
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (flags !== 3'b100) $display("FAIL b2b_flags: got %b expected 100", flags); else passed++;
`endif
    endtask

    task automatic test_host_write();
        logic [15:0] v;
        req_bus.req_valid = 1'b1;
        req_bus.req_op    = 2'b00;
        req_bus.req_rd    = 3'd7;
        req_bus.req_rs1   = 3'd1;
        req_bus.req_rs2   = 3'd2;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 16'h0100;
        tick();
        req_bus.req_valid = 1'b0;
        wr_en = 1'b0;
        checks++; if (alu_i0 !== 16'h0003) $display("FAIL accept_old_rs1: got %h expected 0003", alu_i0); else passed++;
        peek(3'd1, v);
        checks++; if (v !== 16'h0100) $display("FAIL accept_host_r1: got %h expected 0100", v); else passed++;
        tick();
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 16'h0009;
        tick();
        wr_en = 1'b0;
        peek(3'd7, v);
        checks++; if (v !== 16'h0007) $display("FAIL dual_write_r7: got %h expected 0007", v); else passed++;
        peek(3'd2, v);
        checks++; if (v !== 16'h0009) $display("FAIL dual_write_r2: got %h expected 0009", v); else passed++;
    endtask

    task automatic test_reset_exec();
        logic [15:0] v;
        req_bus.req_valid = 1'b1;
        req_bus.req_op    = 2'b00;
        req_bus.req_rd    = 3'd3;
        req_bus.req_rs1   = 3'd1;
        req_bus.req_rs2   = 3'd2;
        tick();
        req_bus.req_valid = 1'b0;
        checks++; if (req_bus.req_ready !== 1'b0) $display("FAIL rexec_in_exec: got %b expected 0", req_bus.req_ready); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({done, done_rd, alu_op} !== 6'b0) $display("FAIL rexec_ctrl: got done/rd/op %b expected 000000", {done, done_rd, alu_op}); else passed++;
        checks++; if ({result, alu_i0, alu_i1} !== 48'h0) $display("FAIL rexec_data: got %h/%h/%h expected zeros", result, alu_i0, alu_i1); else passed++;
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (flags !== 3'b000) $display("FAIL rexec_flags: got %b expected 000", flags); else passed++;
`endif
        for (int i = 0; i < 8; i++) begin
            peek(i[2:0], v);
            checks++; if (v !== 16'h0000) $display("FAIL rexec_r%0d: got %h expected 0000", i, v); else passed++;
        end
        tick();
        checks++; if ({req_bus.req_ready, done} !== 2'b10) $display("FAIL rexec_after: got ready/done %b expected 10", {req_bus.req_ready, done}); else passed++;
        peek(3'd3, v);
        checks++; if (v !== 16'h0000) $display("FAIL rexec_no_wb: got %h expected 0000", v); else passed++;
    endtask

    initial begin
        reset             = 1'b1;
        wr_en             = 1'b0;
        wr_addr           = '0;
        wr_data           = '0;
        rd_addr           = '0;
        req_bus.req_valid = 1'b0;
        req_bus.req_op    = '0;
        req_bus.req_rd    = '0;
        req_bus.req_rs1   = '0;
        req_bus.req_rs2   = '0;
        test_reset();
        test_add();
        test_carry_sub();
        test_logic();
        test_back_to_back();
        test_host_write();
        test_reset_exec();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
